// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM state type, round-count helper and S-box
//
// Purpose: common definitions imported by every AES module.
// Contents:
//   BLOCK_W, RKEY_W : block and round-key widths (128)
//   aes_fsm_e       : encryptor control states IDLE / RUN / DONE
//   aes_nr(nk)      : number of rounds for a key of nk 32-bit words
//   AES_SBOX        : forward S-box, indexed by the input byte
//   xtime(b)        : multiply by {02} in GF(2^8)
package aes_pkg;

  localparam int BLOCK_W = 128;
  localparam int RKEY_W  = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_fsm_e;

  function automatic int aes_nr(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_round.sv
// rtl/aes_round.sv - one combinational AES encryption round
//
// Purpose: SubBytes, ShiftRows, MixColumns and AddRoundKey on one block.
// Ports:
//   state_in    : 128-bit round input, byte 0 in the MSBs, column-major
//   round_key   : 128-bit key added at the end of the round
//   final_round : skip MixColumns (last round)
//   state_out   : 128-bit round result
module aes_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_in,
  input  logic [RKEY_W-1:0]  round_key,
  input  logic               final_round,
  output logic [BLOCK_W-1:0] state_out
);

  logic [BLOCK_W-1:0] shifted;
  logic [BLOCK_W-1:0] mixed;
  logic [7:0]         col [4];

  // SubBytes and ShiftRows commute, so the S-box is applied while
  // gathering: output byte (row r, col c) comes from input col (c+r)%4.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[BLOCK_W-1-8*(4*c+r) -: 8] =
          AES_SBOX[state_in[BLOCK_W-1-8*(4*((c+r)%4)+r) -: 8]];
      end
    end
  end

  // b_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3)
  always_comb begin
    mixed = '0;
    col   = '{default: 8'h00};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        col[r] = shifted[BLOCK_W-1-8*(4*c+r) -: 8];
      end
      for (int r = 0; r < 4; r++) begin
        mixed[BLOCK_W-1-8*(4*c+r) -: 8] =
          xtime(col[r]) ^ xtime(col[(r+1)%4]) ^ col[(r+1)%4] ^ col[(r+2)%4] ^ col[(r+3)%4];
      end
    end
  end

  assign state_out = (final_round ? shifted : mixed) ^ round_key;

endmodule

// File: rtl/aes_encrypt_core.sv
// rtl/aes_encrypt_core.sv - iterative AES-128/192/256 encryptor, one round per clock
//
// Purpose: encrypts one 128-bit block using a caller-supplied expanded key
// schedule, with valid/ready handshakes on both sides.
// Optional feature macro: AES_KEY_LATCH_EN (capture all_keys on accept).
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   data_in   : plaintext block
//   all_keys  : expanded schedule, round key 0 in the MSBs
//   in_valid  : data_in valid
//   in_ready  : core can accept a block
//   data_out  : ciphertext (the state register)
//   out_valid : data_out valid
//   out_ready : consumer takes data_out
//   busy      : block in flight (RUN)
module aes_encrypt_core
  import aes_pkg::*;
#(
  parameter int Nk = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [BLOCK_W-1:0]                data_in,
  input  logic [(aes_nr(Nk)+1)*RKEY_W-1:0]  all_keys,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [BLOCK_W-1:0]                data_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy
);

  localparam int         Nr      = aes_nr(Nk);
  localparam int         KEYS_W  = (Nr + 1) * RKEY_W;
  localparam logic [3:0] NR_LAST = 4'(Nr);

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_encrypt_core: Nk must be 4, 6 or 8");
  end

  aes_fsm_e           fsm;
  aes_fsm_e           fsm_next;
  logic [3:0]         round;
  logic [BLOCK_W-1:0] state;
  logic [BLOCK_W-1:0] round_out;
  logic [KEYS_W-1:0]  keys;
  logic [RKEY_W-1:0]  rk_sel [Nr+1];
  logic               accept;
  logic               final_round;

  // A new block can enter in the same cycle the previous result leaves.
  assign in_ready    = reset && (fsm == IDLE || (fsm == DONE && out_ready));
  assign accept      = in_valid && in_ready;
  assign final_round = (round == NR_LAST);

`ifdef AES_KEY_LATCH_EN
  logic [KEYS_W-1:0] key_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q <= '0;
    end else if (accept) begin
      key_q <= all_keys;
    end
  end

  assign keys = key_q;
`else
  assign keys = all_keys;
`endif

  for (genvar r = 0; r <= Nr; r++) begin : g_rk
    assign rk_sel[r] = keys[KEYS_W-1-r*RKEY_W -: RKEY_W];
  end

  aes_round u_round (
    .state_in    (state),
    .round_key   (rk_sel[round]),
    .final_round (final_round),
    .state_out   (round_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm <= IDLE;
    end else begin
      fsm <= fsm_next;
    end
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE:    if (accept) fsm_next = RUN;
      RUN:     if (final_round) fsm_next = DONE;
      DONE:    if (out_ready) fsm_next = accept ? RUN : IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  // Round 0 (initial AddRoundKey) is folded into the load so RUN only
  // ever performs full or final rounds. The first key is taken straight
  // from all_keys since any latched copy is only written on this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= '0;
      round <= '0;
    end else if (accept) begin
      state <= data_in ^ all_keys[KEYS_W-1 -: RKEY_W];
      round <= 4'd1;
    end else if (fsm == RUN) begin
      state <= round_out;
      if (!final_round) begin
        round <= round + 4'd1;
      end
    end
  end

  assign data_out  = state;
  assign out_valid = (fsm == DONE);
  assign busy      = (fsm == RUN);

endmodule

// File: tb/tb_aes_encrypt_core.sv
// tb/tb_aes_encrypt_core.sv - scoreboard bench for aes_encrypt_core (Nk 4, 6, 8)
module tb_aes_encrypt_core;

  localparam logic [127:0] PT_KAT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct {
    logic [127:0] data;
    int           acc_edge;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           reset;
  logic [127:0]   d_in;
  logic           in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0]   data_out;
  logic [1919:0]  sched4;
  logic [1407:0]  keys4;
  assign keys4 = sched4[1919 -: 1408];

  logic [127:0]   x_in;
  logic           x_valid;
  logic           x_oready;
  logic [1919:0]  s6, s8;
  logic [1663:0]  keys6;
  logic [1919:0]  keys8;
  logic           r6, v6, b6, r8, v8, b8;
  logic [127:0]   do6, do8;
  assign keys6 = s6[1919 -: 1664];
  assign keys8 = s8;

  aes_encrypt_core #(.Nk(4)) dut4 (
    .clk(clk), .reset(reset), .data_in(d_in), .all_keys(keys4), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy));
  aes_encrypt_core #(.Nk(6)) dut6 (
    .clk(clk), .reset(reset), .data_in(x_in), .all_keys(keys6), .in_valid(x_valid),
    .in_ready(r6), .data_out(do6), .out_valid(v6), .out_ready(x_oready), .busy(b6));
  aes_encrypt_core #(.Nk(8)) dut8 (
    .clk(clk), .reset(reset), .data_in(x_in), .all_keys(keys8), .in_valid(x_valid),
    .in_ready(r8), .data_out(do8), .out_valid(v8), .out_ready(x_oready), .busy(b8));

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  exp_t cur;
  int   or_mode = 1;
  int   n_acc = 0;
  int   n_xfer = 0;
  int   last_acc = -1;
  logic spacing_on = 1'b0;
  logic ov_prev = 1'b0;
  logic [7:0] sbox_t [256];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic chk_i(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // ---- reference model: GF(2^8) arithmetic, S-box from inverse + affine ----
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(x));
      end
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Full schedule, round key 0 at [1919:1792]; unused tail is zero.
  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   tmp;
    logic [7:0]    rc;
    logic [1919:0] res;
    int            nw;
    nw  = 4 * (nk + 7);
    res = '0;
    rc  = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < nw; i++) res[1919-32*i -: 32] = w[i];
    return res;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [1919:0] sch, input int nr);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ sch[1919-8*(4*c+r) -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = sbox_t[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rd < nr)
            s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
          s[r][c] = s[r][c] ^ sch[1919-128*rd-8*(4*c+r) -: 8];
        end
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  // ---- driver helpers (Nk=4 instance) ----
  task automatic send(input logic [127:0] pt, input logic [255:0] key);
    logic [1919:0] s;
    exp_t          e;
    int            n;
    s = expand(key, 4);
    @(negedge clk);
    d_in     = pt;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk_i("accept timeout", int'(in_ready), 1);
      in_valid = 1'b0;
    end else begin
      sched4     = s;
      e.data     = aes_ref(pt, s, 10);
      e.acc_edge = cyc + 1;
      exp_q.push_back(e);
      n_acc++;
      if (spacing_on && last_acc >= 0) chk_i("stream spacing", e.acc_edge - last_acc, 11);
      last_acc = e.acc_edge;
    end
  endtask

  task automatic finish_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((exp_q.size() != 0 || out_valid || busy) && n < 600);
    chk_i("drain", exp_q.size() + int'(out_valid) + int'(busy), 0);
  endtask

  // ---- monitor: drives out_ready, pops and checks each result ----
  always @(negedge clk) begin
    case (or_mode)
      0:       out_ready = 1'($urandom_range(0, 1));
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
    #1;
    if (!reset) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (exp_q.size() == 0) begin
          chk_i("spurious out_valid", exp_q.size(), 1);
        end else begin
          cur = exp_q.pop_front();
          chk_i("latency", cyc - cur.acc_edge, 10);
          chk("ciphertext", data_out, cur.data);
        end
      end else if (out_valid) begin
        chk("held data_out", data_out, cur.data);
      end
      if (out_valid && !out_ready) chk_i("in_ready while stalled", int'(in_ready), 0);
      if (out_valid && out_ready) n_xfer++;
      ov_prev = out_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] p, cap6, cap8;
    logic [255:0] k, k6, k8;
    int           g, got6, got8, xfer0;

    reset    = 1'b0;
    in_valid = 1'b0;
    d_in     = '0;
    sched4   = '0;
    x_in     = '0;
    x_valid  = 1'b0;
    x_oready = 1'b1;
    s6       = '0;
    s8       = '0;
    build_sbox();

    // reset state
    @(negedge clk);
    #1;
    chk_i("reset in_ready", int'(in_ready), 0);
    chk_i("reset out_valid", int'(out_valid), 0);
    chk_i("reset busy", int'(busy), 0);
    chk("reset data_out", data_out, 128'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_i("idle in_ready", int'(in_ready), 1);

    // FIPS-197 C.1
    or_mode = 1;
    send(PT_KAT, KEY128);
    finish_in();
    wait_idle();
    chk("C.1 ciphertext", data_out, CT128);

    // backpressure
    or_mode = 2;
    send(rand128(), rand256());
    finish_in();
    g = 0;
    while (!out_valid && g < 40) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk_i("bp out_valid seen", int'(out_valid), 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      #1;
      chk_i("bp in_ready low", int'(in_ready), 0);
      chk_i("bp out_valid held", int'(out_valid), 1);
    end
    xfer0   = n_xfer;
    or_mode = 1;
    @(negedge clk);
    #1;
    chk_i("bp release in_ready", int'(in_ready), 1);
    @(negedge clk);
    #1;
    chk_i("bp one transfer", n_xfer - xfer0, 1);
    chk_i("bp out_valid dropped", int'(out_valid), 0);
    chk_i("bp in_ready after", int'(in_ready), 1);

    // streaming, shared key
    k          = rand256();
    last_acc   = -1;
    spacing_on = 1'b1;
    for (int i = 0; i < 4; i++) send(rand128(), k);
    spacing_on = 1'b0;
    finish_in();
    wait_idle();

    // reset at round 5
    send(PT_KAT, KEY128);
    repeat (5) @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_i("mid reset out_valid", int'(out_valid), 0);
    chk("mid reset data_out", data_out, 128'h0);
    chk_i("mid reset busy", int'(busy), 0);
    chk_i("mid reset in_ready", int'(in_ready), 0);
    n_acc = n_acc - exp_q.size();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send(PT_KAT, KEY128);
    finish_in();
    wait_idle();
    chk("C.1 after reset", data_out, CT128);

    // random traffic with random backpressure and gaps
    or_mode = 0;
    for (int i = 0; i < 24; i++) begin
      send(rand128(), rand256());
      g = $urandom_range(0, 3);
      if (g > 0) begin
        finish_in();
        repeat (g - 1) @(negedge clk);
      end
    end
    finish_in();
    or_mode = 1;
    wait_idle();

`ifdef AES_KEY_LATCH_EN
    send(PT_KAT, KEY128);
    @(negedge clk);
    in_valid = 1'b0;
    sched4   = {rand256(), rand256(), rand256(), rand256(), rand256(), rand256(), rand128(), rand128(), rand128()};
    wait_idle();
    chk("latched key C.1", data_out, CT128);
`endif

    // AES-192 / AES-256 instances
    for (int t = 0; t < 3; t++) begin
      p  = (t == 0) ? PT_KAT : rand128();
      k6 = (t == 0) ? KEY192 : rand256();
      k8 = (t == 0) ? KEY256 : rand256();
      s6 = expand(k6, 6);
      s8 = expand(k8, 8);
      @(negedge clk);
      x_in    = p;
      x_valid = 1'b1;
      #1;
      chk_i("n6 in_ready", int'(r6), 1);
      chk_i("n8 in_ready", int'(r8), 1);
      got6 = -1;
      got8 = -1;
      cap6 = '0;
      cap8 = '0;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        if (j == 0) x_valid = 1'b0;
        #1;
        if (v6 && got6 < 0) begin
          got6 = j;
          cap6 = do6;
        end
        if (v8 && got8 < 0) begin
          got8 = j;
          cap8 = do8;
        end
      end
      chk_i("n6 latency", got6, 12);
      chk_i("n8 latency", got8, 14);
      chk("n6 ciphertext", cap6, aes_ref(p, s6, 12));
      chk("n8 ciphertext", cap8, aes_ref(p, s8, 14));
      if (t == 0) begin
        chk("C.2 ciphertext", cap6, CT192);
        chk("C.3 ciphertext", cap8, CT256);
      end
    end

    chk_i("queue empty", exp_q.size(), 0);
    chk_i("transfers match accepts", n_xfer, n_acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
